// File: rtl/turtle_mem_pkg.sv
// Shared definitions for the turtle data-memory path: store FSM states,
// funct3 store-size encodings and the store exception numbers.
package turtle_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } store_state_t;

    localparam logic [2:0] STORE_BYTE = 3'b000;
    localparam logic [2:0] STORE_HALF = 3'b001;
    localparam logic [2:0] STORE_WORD = 3'b010;

    localparam logic [5:0] EXCEPTION_STORE_MISALIGN = 6'd6;
    localparam logic [5:0] EXCEPTION_STORE_ACCESS   = 6'd7;

endpackage

// File: rtl/store_lane_align.sv
// Places right-justified store data onto the byte lanes selected by the low
// address bits and produces the matching byte strobes.
module store_lane_align
    import turtle_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] val,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    // Anything other than byte or half is treated as a full word, including 2'b11.
    always_comb begin
        wstrb = 4'b1111;
        wdata = val;
        if (size == STORE_BYTE[1:0]) begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{val[7:0]}};
        end else if (size == STORE_HALF[1:0]) begin
            wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{val[15:0]}};
        end
    end

endmodule

// File: rtl/store_mem_ctrl.sv
// Store sequencer: captures one store, drives a single-outstanding req/ack
// write to data memory and reports completion or an access fault.
module store_mem_ctrl
    import turtle_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_val,
    input  logic [1:0]  store_size,
    input  logic        store_valid,
    output logic        store_ready,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic [5:0]  exception_num_out,
    output logic        exception_valid_out
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    store_state_t state;
    store_state_t next_state;
    logic [31:0]  tmo_cnt;
    logic [3:0]   align_wstrb;
    logic [31:0]  align_wdata;
    logic         accept;
    logic         timeout_hit;

    store_lane_align u_align (
        .addr_lo (store_addr[1:0]),
        .size    (store_size),
        .val     (store_val),
        .wstrb   (align_wstrb),
        .wdata   (align_wdata)
    );

    assign accept      = (state == IDLE) && store_valid;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An ack in the same cycle as the timeout wins; mem_err picks the outcome.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (store_valid) next_state = REQ;
            REQ: begin
                if (mem_ack) begin
                    next_state = mem_err ? FAULT : DONE;
                end else if (timeout_hit) begin
                    next_state = FAULT;
                end
            end
            DONE:  next_state = IDLE;
            FAULT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Write port fields are captured once on accept and held through the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            tmo_cnt   <= '0;
        end else if (accept) begin
            mem_addr  <= {store_addr[31:2], 2'b00};
            mem_wdata <= align_wdata;
            mem_wstrb <= align_wstrb;
            tmo_cnt   <= '0;
        end else if ((state == REQ) && !mem_ack) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign store_ready         = (state == IDLE);
    assign busy                = (state != IDLE);
    assign mem_req             = (state == REQ);
    assign done                = (state == DONE);
    assign exception_valid_out = (state == FAULT);
    assign exception_num_out   = EXCEPTION_STORE_ACCESS;

endmodule
